// File: rtl/bk_ram_sequencer.sv
// Backup-RAM save/load sequencer.
// Moves the battery RAM image between backup RAM port B and the HPS SD image,
// one sector per sd_rd/sd_wr + sd_ack handshake. It also writes the default
// header words when formatting.
// Ports:
//   clk_sys, reset                 clock, async active-high reset
//   cart_download, img_*           cart download and save image mount status
//   load_req, save_req, format_req request levels, acted on at rising edges
//   autosave, osd_status, bram_wr  autosave control and core write strobe
//   sd_ack, sd_lba, sd_rd, sd_wr   hps_io sector handshake
//   bk_ena, busy, loading, pending status outputs
//   fmt_we, fmt_addr, fmt_data     default-word writes into RAM port B
//   fmt_active                     port B is owned by the format engine
module bk_ram_sequencer #(
  parameter int unsigned SECTORS  = 16,
  parameter int unsigned DEFWORDS = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cart_download,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        img_size_nz,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave,
  input  logic        osd_status,
  input  logic        bram_wr,
  input  logic        format_req,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        busy,
  output logic        loading,
  output logic        pending,
  output logic        fmt_we,
  output logic [1:0]  fmt_addr,
  output logic [15:0] fmt_data,
  output logic        fmt_active
);

  localparam int unsigned LBAW = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam logic [LBAW-1:0] LAST_LBA = LBAW'(SECTORS - 1);
  localparam logic [1:0]      FMT_LAST = 2'(DEFWORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, FMT} state_t;

  state_t          state_q;
  logic [LBAW-1:0] lba_q;
  logic            sd_rd_q, sd_wr_q, bk_ena_q, busy_q, loading_q, pending_q;
  logic            fmt_pend_q, fmt_we_q, fmt_active_q;
  logic [1:0]      fmt_addr_q;
  logic [15:0]     fmt_data_q;

  // Previous-cycle samples for edge detection
  logic load_req_q, save_trig_q, format_req_q, cart_download_q, sd_ack_q;

  logic save_trig, save_rise, load_trig, fmt_rise, ack_rise, ack_fall, dl_rise;

  // HuBM default header
  function automatic logic [15:0] def_word(input logic [1:0] a);
    case (a)
      2'd0:    def_word = 16'h5548;
      2'd1:    def_word = 16'h4D42;
      2'd2:    def_word = 16'h8800;
      2'd3:    def_word = 16'h8010;
      default: def_word = 16'h0000;
    endcase
  endfunction

  // Request edge detection; a download finishing with a non-empty image is a load trigger
  always_comb begin
    save_trig = save_req | (autosave & pending_q & osd_status);
    save_rise = save_trig & ~save_trig_q;
    load_trig = (load_req & ~load_req_q) | (~cart_download & cart_download_q & img_size_nz);
    fmt_rise  = format_req & ~format_req_q;
    ack_rise  = sd_ack & ~sd_ack_q;
    ack_fall  = ~sd_ack & sd_ack_q;
    dl_rise   = cart_download & ~cart_download_q;
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      lba_q           <= '0;
      sd_rd_q         <= 1'b0;
      sd_wr_q         <= 1'b0;
      bk_ena_q        <= 1'b0;
      busy_q          <= 1'b0;
      loading_q       <= 1'b0;
      pending_q       <= 1'b0;
      fmt_pend_q      <= 1'b0;
      fmt_we_q        <= 1'b0;
      fmt_active_q    <= 1'b0;
      fmt_addr_q      <= 2'd0;
      fmt_data_q      <= 16'h0000;
      load_req_q      <= 1'b0;
      save_trig_q     <= 1'b0;
      format_req_q    <= 1'b0;
      cart_download_q <= 1'b0;
      sd_ack_q        <= 1'b0;
    end else begin
      load_req_q      <= load_req;
      save_trig_q     <= save_trig;
      format_req_q    <= format_req;
      cart_download_q <= cart_download;
      sd_ack_q        <= sd_ack;

      // A mount during a download wins over the clear at the download's start
      if (cart_download && img_mounted && !img_readonly) bk_ena_q <= 1'b1;
      else if (dl_rise)                                  bk_ena_q <= 1'b0;

      // Any transfer flushes the pending flag, even against a same-cycle write
      if (busy_q)                                     pending_q <= 1'b0;
      else if (bk_ena_q && !osd_status && bram_wr)    pending_q <= 1'b1;

      if (fmt_rise) fmt_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bk_ena_q && load_trig) begin
            state_q   <= REQ;
            lba_q     <= '0;
            sd_rd_q   <= 1'b1;
            sd_wr_q   <= 1'b0;
            loading_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (bk_ena_q && save_rise) begin
            state_q   <= REQ;
            lba_q     <= '0;
            sd_rd_q   <= 1'b0;
            sd_wr_q   <= 1'b1;
            loading_q <= 1'b0;
            busy_q    <= 1'b1;
          end else if (fmt_pend_q || fmt_rise) begin
            state_q      <= FMT;
            fmt_pend_q   <= 1'b0;
            fmt_we_q     <= 1'b1;
            fmt_active_q <= 1'b1;
            fmt_addr_q   <= 2'd0;
            fmt_data_q   <= def_word(2'd0);
          end
        end
        REQ: begin
          if (ack_rise) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (ack_fall) begin
            if (lba_q == LAST_LBA) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              loading_q <= 1'b0;
              lba_q     <= '0;
            end else begin
              lba_q   <= lba_q + LBAW'(1);
              sd_rd_q <= loading_q;
              sd_wr_q <= ~loading_q;
              state_q <= REQ;
            end
          end
        end
        FMT: begin
          if (fmt_addr_q == FMT_LAST) begin
            fmt_we_q     <= 1'b0;
            fmt_active_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            fmt_addr_q <= fmt_addr_q + 2'd1;
            fmt_data_q <= def_word(fmt_addr_q + 2'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd_lba     = 32'(lba_q);
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign bk_ena     = bk_ena_q;
  assign busy       = busy_q;
  assign loading    = loading_q;
  assign pending    = pending_q;
  assign fmt_we     = fmt_we_q;
  assign fmt_addr   = fmt_addr_q;
  assign fmt_data   = fmt_data_q;
  assign fmt_active = fmt_active_q;

endmodule
